// File: rtl/mem_txn_fsm.sv
// Transaction sequencer between the host command port and the QSPI flash controller.
// Reads stream through a small FIFO to the host; writes are serialised MSB-first.
module mem_txn_fsm #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_LEN    = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    input  logic         cmd_rw,
    input  logic [23:0]  cmd_addr,
    input  logic [8:0]   cmd_len,
    input  logic [255:0] wr_data,
    input  logic         wr_data_valid,
    output logic         fsm_ready,
    output logic [7:0]   rd_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic         txn_done,
    output logic         txn_err,
    output logic         qspi_start,
    output logic         qspi_rw,
    output logic [23:0]  qspi_addr,
    output logic [8:0]   qspi_len,
    input  logic         qspi_ready,
    input  logic [7:0]   qspi_rd_data,
    input  logic         qspi_rd_valid,
    output logic         qspi_rd_ready,
    output logic [7:0]   qspi_wr_data,
    output logic         qspi_wr_valid,
    input  logic         qspi_wr_ready,
    input  logic         qspi_done
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] EMPTY_CNT = (AW+1)'(0);
    localparam logic [8:0]  PAY_BYTES = 9'd32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        ISSUE     = 3'd2,
        WRITE     = 3'd3,
        READ      = 3'd4,
        WAIT_DONE = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t         state_r;
    logic           rw_r;
    logic [23:0]    addr_r;
    logic [8:0]     len_r;
    logic [5:0]     cnt_r;
    logic           err_r;
    logic           qdone_seen_r;
    logic [255:0]   shift_r;
    logic           fsm_ready_r;
    logic           txn_done_r;
    logic           txn_err_r;
    logic           qspi_start_r;
    logic           qspi_wr_valid_r;

    logic [7:0]     fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]  wptr_r;
    logic [AW-1:0]  rptr_r;
    logic [AW:0]    fifo_cnt_r;

    logic           rd_valid_s;
    logic           qspi_rd_ready_s;
    logic           qspi_hs_s;
    logic           push_s;
    logic           extra_s;
    logic           pop_s;
    logic [AW:0]    fifo_cnt_next_s;
    logic [5:0]     cnt_next_s;
    logic           wr_last_s;
    logic           len_bad_s;
    logic [8:0]     pad_s;
    logic           rd_err_s;

    // Handshake decode, FIFO occupancy look-ahead and command validation.
    always_comb begin
        rd_valid_s      = (fifo_cnt_r != EMPTY_CNT);
        qspi_rd_ready_s = (state_r == READ) && (fifo_cnt_r != FULL_CNT);
        qspi_hs_s       = qspi_rd_valid && qspi_rd_ready_s;
        // Bytes beyond the requested length are accepted but never stored.
        push_s          = qspi_hs_s && (cnt_r != len_r[5:0]);
        extra_s         = qspi_hs_s && (cnt_r == len_r[5:0]);
        pop_s           = rd_valid_s && rd_ready;
        fifo_cnt_next_s = fifo_cnt_r + (AW+1)'(push_s) - (AW+1)'(pop_s);
        cnt_next_s      = cnt_r + 6'(push_s);
        wr_last_s       = qspi_wr_ready && ((cnt_r + 6'd1) == len_r[5:0]);
        len_bad_s       = (cmd_len == 9'd0) || (cmd_len > 9'(MAX_LEN));
        pad_s           = PAY_BYTES - len_r;
        rd_err_s        = err_r || extra_s || (cnt_next_s != len_r[5:0]);
    end

    // Read-data FIFO storage and pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r     <= {AW{1'b0}};
            rptr_r     <= {AW{1'b0}};
            fifo_cnt_r <= EMPTY_CNT;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 8'd0;
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wptr_r] <= qspi_rd_data;
                wptr_r             <= wptr_r + AW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + AW'(1);
            end
            fifo_cnt_r <= fifo_cnt_next_s;
        end
    end

    // Transaction state machine with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            rw_r            <= 1'b0;
            addr_r          <= 24'd0;
            len_r           <= 9'd0;
            cnt_r           <= 6'd0;
            err_r           <= 1'b0;
            qdone_seen_r    <= 1'b0;
            shift_r         <= 256'd0;
            fsm_ready_r     <= 1'b1;
            txn_done_r      <= 1'b0;
            txn_err_r       <= 1'b0;
            qspi_start_r    <= 1'b0;
            qspi_wr_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        rw_r         <= cmd_rw;
                        addr_r       <= cmd_addr;
                        len_r        <= cmd_len;
                        cnt_r        <= 6'd0;
                        qdone_seen_r <= 1'b0;
                        fsm_ready_r  <= 1'b0;
                        if (len_bad_s) begin
                            err_r   <= 1'b1;
                            state_r <= DONE;
                        end else if (cmd_rw) begin
                            qspi_start_r <= 1'b1;
                            state_r      <= ISSUE;
                        end else begin
                            state_r <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    // Left-justify so the first byte to send always sits at the top.
                    if (wr_data_valid) begin
                        shift_r      <= wr_data << {pad_s, 3'b000};
                        qspi_start_r <= 1'b1;
                        state_r      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (qspi_ready) begin
                        qspi_start_r <= 1'b0;
                        if (rw_r) begin
                            state_r <= READ;
                        end else begin
                            qspi_wr_valid_r <= 1'b1;
                            state_r         <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (wr_last_s) begin
                        shift_r         <= {shift_r[247:0], 8'd0};
                        cnt_r           <= cnt_r + 6'd1;
                        qspi_wr_valid_r <= 1'b0;
                        if (qspi_done) begin
                            txn_done_r <= 1'b1;
                            txn_err_r  <= err_r;
                            state_r    <= DONE;
                        end else begin
                            state_r <= WAIT_DONE;
                        end
                    end else if (qspi_done) begin
                        err_r           <= 1'b1;
                        qspi_wr_valid_r <= 1'b0;
                        txn_done_r      <= 1'b1;
                        txn_err_r       <= 1'b1;
                        state_r         <= DONE;
                    end else if (qspi_wr_ready) begin
                        shift_r <= {shift_r[247:0], 8'd0};
                        cnt_r   <= cnt_r + 6'd1;
                    end
                end
                READ: begin
                    cnt_r <= cnt_next_s;
                    if (qspi_done) begin
                        qdone_seen_r <= 1'b1;
                    end
                    if ((qdone_seen_r || qspi_done) && (fifo_cnt_next_s == EMPTY_CNT)) begin
                        err_r      <= rd_err_s;
                        txn_done_r <= 1'b1;
                        txn_err_r  <= rd_err_s;
                        state_r    <= DONE;
                    end else if (extra_s) begin
                        err_r <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (qspi_done) begin
                        txn_done_r <= 1'b1;
                        txn_err_r  <= err_r;
                        state_r    <= DONE;
                    end
                end
                DONE: begin
                    // Rejected commands arrive without the pulse armed and raise it here.
                    if (!txn_done_r) begin
                        txn_done_r <= 1'b1;
                        txn_err_r  <= err_r;
                    end else begin
                        txn_done_r  <= 1'b0;
                        txn_err_r   <= 1'b0;
                        err_r       <= 1'b0;
                        fsm_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r         <= IDLE;
                    fsm_ready_r     <= 1'b1;
                    qspi_start_r    <= 1'b0;
                    qspi_wr_valid_r <= 1'b0;
                    txn_done_r      <= 1'b0;
                    txn_err_r       <= 1'b0;
                end
            endcase
        end
    end

    assign fsm_ready     = fsm_ready_r;
    assign rd_data       = fifo_mem_r[rptr_r];
    assign rd_valid      = rd_valid_s;
    assign txn_done      = txn_done_r;
    assign txn_err       = txn_err_r;
    assign qspi_start    = qspi_start_r;
    assign qspi_rw       = rw_r;
    assign qspi_addr     = addr_r;
    assign qspi_len      = len_r;
    assign qspi_rd_ready = qspi_rd_ready_s;
    assign qspi_wr_data  = shift_r[255:248];
    assign qspi_wr_valid = qspi_wr_valid_r;

endmodule

// File: tb/tb_mem_txn_fsm.sv
// Bench for mem_txn_fsm: scripted host and flash models with scoreboard queues
// holding the bytes expected on the read stream and on the write serialiser.
`timescale 1ns/1ps
module tb_mem_txn_fsm;
    localparam int FIFO_DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_rw;
    logic [23:0]  cmd_addr;
    logic [8:0]   cmd_len;
    logic [255:0] wr_data;
    logic         wr_data_valid;
    logic         fsm_ready;
    logic [7:0]   rd_data;
    logic         rd_valid;
    logic         rd_ready;
    logic         txn_done;
    logic         txn_err;
    logic         qspi_start;
    logic         qspi_rw;
    logic [23:0]  qspi_addr;
    logic [8:0]   qspi_len;
    logic         qspi_ready;
    logic [7:0]   qspi_rd_data;
    logic         qspi_rd_valid;
    logic         qspi_rd_ready;
    logic [7:0]   qspi_wr_data;
    logic         qspi_wr_valid;
    logic         qspi_wr_ready;
    logic         qspi_done;

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   exp_q[$];
    logic [255:0] pay_r;

    mem_txn_fsm #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_LEN(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid),
        .fsm_ready(fsm_ready), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .txn_done(txn_done), .txn_err(txn_err),
        .qspi_start(qspi_start), .qspi_rw(qspi_rw), .qspi_addr(qspi_addr), .qspi_len(qspi_len),
        .qspi_ready(qspi_ready), .qspi_rd_data(qspi_rd_data), .qspi_rd_valid(qspi_rd_valid),
        .qspi_rd_ready(qspi_rd_ready), .qspi_wr_data(qspi_wr_data), .qspi_wr_valid(qspi_wr_valid),
        .qspi_wr_ready(qspi_wr_ready), .qspi_done(qspi_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] flash_byte(input logic [23:0] a, input int i);
        return a[7:0] ^ 8'(i * 37);
    endfunction

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 24'd0; cmd_len = 9'd0;
        wr_data = 256'd0; wr_data_valid = 1'b0; rd_ready = 1'b0; qspi_ready = 1'b0;
        qspi_rd_data = 8'd0; qspi_rd_valid = 1'b0; qspi_wr_ready = 1'b0; qspi_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({txn_done, txn_err, qspi_start, qspi_wr_valid, qspi_rd_ready, rd_valid} !== 6'b0) begin
            errors++; $display("FAIL reset_strobes: got %b want 000000", {txn_done, txn_err, qspi_start, qspi_wr_valid, qspi_rd_ready, rd_valid}); end
        checks++; if (fsm_ready !== 1'b1) begin errors++; $display("FAIL reset_fsm_ready: got %b want 1", fsm_ready); end
        checks++; if ({rd_data, qspi_wr_data, qspi_rw, qspi_addr, qspi_len} !== 50'd0) begin
            errors++; $display("FAIL reset_data: got %h want 0", {rd_data, qspi_wr_data, qspi_rw, qspi_addr, qspi_len}); end
        rst = 1'b0;
    endtask

    task automatic test_read(input int len, input logic [23:0] addr, input int stall, input string name);
        int sent = 0, popped = 0, dones = 0, cyc = 0, blocked_at = -1;
        bit done_sent = 1'b0, last_pop = 1'b0;
        logic [7:0] b, exp_b;
        exp_q.delete();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = addr; cmd_len = 9'(len);
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (qspi_start !== 1'b1) begin errors++; $display("FAIL %s start_latency: got %b want 1", name, qspi_start); end
        checks++; if ({qspi_rw, qspi_addr, qspi_len} !== {1'b1, addr, 9'(len)}) begin
            errors++; $display("FAIL %s fields: got %h want %h", name, {qspi_rw, qspi_addr, qspi_len}, {1'b1, addr, 9'(len)}); end
        checks++; if (fsm_ready !== 1'b0) begin errors++; $display("FAIL %s busy: got %b want 0", name, fsm_ready); end
        @(negedge clk);
        checks++; if (qspi_start !== 1'b1) begin errors++; $display("FAIL %s start_hold: got %b want 1", name, qspi_start); end
        qspi_ready = 1'b1;
        @(negedge clk);
        qspi_ready = 1'b0;
        checks++; if (qspi_start !== 1'b0) begin errors++; $display("FAIL %s start_drop: got %b want 0", name, qspi_start); end
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            qspi_done = 1'b0;
            // A stray command while busy must not disturb the transaction.
            cmd_valid = (cyc <= 2); cmd_rw = 1'b0; cmd_len = 9'd5;
            if (last_pop) begin
                checks++; if (txn_done !== 1'b1) begin errors++; $display("FAIL %s done_latency: got %b want 1", name, txn_done); end
                last_pop = 1'b0;
            end
            if (txn_done) begin
                dones++;
                checks++; if (txn_err !== 1'b0) begin errors++; $display("FAIL %s txn_err: got %b want 0", name, txn_err); end
            end
            if (dones > 0 && popped == len) break;
            rd_ready = (cyc > stall);
            if (rd_valid && rd_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL %s unexpected_byte: got %h want none", name, rd_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (rd_data !== exp_b) begin errors++; $display("FAIL %s rd_data[%0d]: got %h want %h", name, popped, rd_data, exp_b); end
                end
                popped++;
                if (popped == len) last_pop = 1'b1;
            end
            if (sent < len) begin
                b = flash_byte(addr, sent);
                qspi_rd_valid = 1'b1; qspi_rd_data = b;
                if (qspi_rd_ready) begin exp_q.push_back(b); sent++; end
                else if (blocked_at < 0) blocked_at = sent;
            end else begin
                qspi_rd_valid = 1'b0;
                if (!done_sent) begin qspi_done = 1'b1; done_sent = 1'b1; end
            end
        end
        cmd_valid = 1'b0; qspi_rd_valid = 1'b0; qspi_done = 1'b0;
        checks++; if (dones != 1) begin errors++; $display("FAIL %s done_count: got %0d want 1", name, dones); end
        checks++; if (popped != len) begin errors++; $display("FAIL %s bytes_delivered: got %0d want %0d", name, popped, len); end
        if (stall > FIFO_DEPTH) begin
            checks++; if (blocked_at != FIFO_DEPTH) begin errors++; $display("FAIL %s backpressure_at: got %0d want %0d", name, blocked_at, FIFO_DEPTH); end
        end
        @(negedge clk);
        checks++; if ({txn_done, fsm_ready} !== 2'b01) begin errors++; $display("FAIL %s back_to_idle: got %b want 01", name, {txn_done, fsm_ready}); end
        checks++; if (qspi_len !== 9'(len)) begin errors++; $display("FAIL %s busy_cmd_ignored: got %0d want %0d", name, qspi_len, len); end
    endtask

    task automatic test_write(input int len, input logic [255:0] payload, input int done_after, input string name);
        int stop, hs = 0, cyc = 0;
        logic rdy;
        logic [7:0] exp_b;
        stop = (done_after > 0) ? done_after : len;
        exp_q.delete();
        for (int k = 0; k < len; k++) exp_q.push_back(payload[8*(len-k)-1 -: 8]);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 24'h00C0DE; cmd_len = 9'(len);
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if ({fsm_ready, qspi_start} !== 2'b00) begin errors++; $display("FAIL %s load_wait: got %b want 00", name, {fsm_ready, qspi_start}); end
        wr_data = payload; wr_data_valid = 1'b1;
        @(negedge clk);
        wr_data_valid = 1'b0;
        checks++; if ({qspi_start, qspi_rw, qspi_len} !== {2'b10, 9'(len)}) begin
            errors++; $display("FAIL %s issue: got %h want %h", name, {qspi_start, qspi_rw, qspi_len}, {2'b10, 9'(len)}); end
        qspi_ready = 1'b1;
        @(negedge clk);
        qspi_ready = 1'b0;
        checks++; if ({qspi_start, qspi_wr_valid} !== 2'b01) begin errors++; $display("FAIL %s write_entry: got %b want 01", name, {qspi_start, qspi_wr_valid}); end
        while (hs < stop && cyc < 400) begin
            rdy = ($urandom_range(0, 3) != 0);
            qspi_wr_ready = rdy;
            if (qspi_wr_valid && rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL %s unexpected_wr: got %h want none", name, qspi_wr_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (qspi_wr_data !== exp_b) begin errors++; $display("FAIL %s wr_data[%0d]: got %h want %h", name, hs, qspi_wr_data, exp_b); end
                end
                hs++;
            end
            cyc++;
            @(negedge clk);
        end
        qspi_wr_ready = 1'b0;
        checks++; if (hs != stop) begin errors++; $display("FAIL %s handshakes: got %0d want %0d", name, hs, stop); end
        if (done_after > 0) begin
            checks++; if (qspi_wr_valid !== 1'b1) begin errors++; $display("FAIL %s still_writing: got %b want 1", name, qspi_wr_valid); end
            qspi_done = 1'b1;
            @(negedge clk);
            qspi_done = 1'b0;
            checks++; if ({txn_done, txn_err, qspi_wr_valid} !== 3'b110) begin
                errors++; $display("FAIL %s early_done: got %b want 110", name, {txn_done, txn_err, qspi_wr_valid}); end
            exp_q.delete();
        end else begin
            checks++; if ({qspi_wr_valid, txn_done} !== 2'b00) begin errors++; $display("FAIL %s wait_done: got %b want 00", name, {qspi_wr_valid, txn_done}); end
            checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL %s bytes_left: got %0d want 0", name, exp_q.size()); end
            repeat (2) @(negedge clk);
            qspi_done = 1'b1;
            @(negedge clk);
            qspi_done = 1'b0;
            checks++; if ({txn_done, txn_err} !== 2'b10) begin errors++; $display("FAIL %s done_after_qspi: got %b want 10", name, {txn_done, txn_err}); end
        end
        @(negedge clk);
        checks++; if ({txn_done, fsm_ready} !== 2'b01) begin errors++; $display("FAIL %s back_to_idle: got %b want 01", name, {txn_done, fsm_ready}); end
    endtask

    task automatic test_bad_len(input int len, input string name);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 24'hABCDEF; cmd_len = 9'(len);
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if ({txn_done, qspi_start, fsm_ready} !== 3'b000) begin errors++; $display("FAIL %s cycle1: got %b want 000", name, {txn_done, qspi_start, fsm_ready}); end
        @(negedge clk);
        checks++; if ({txn_done, txn_err, qspi_start} !== 3'b110) begin errors++; $display("FAIL %s err_pulse: got %b want 110", name, {txn_done, txn_err, qspi_start}); end
        @(negedge clk);
        checks++; if ({txn_done, txn_err, fsm_ready} !== 3'b001) begin errors++; $display("FAIL %s err_clear: got %b want 001", name, {txn_done, txn_err, fsm_ready}); end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 24'h000100; cmd_len = 9'd8;
        @(negedge clk);
        cmd_valid = 1'b0; qspi_ready = 1'b1;
        @(negedge clk);
        qspi_ready = 1'b0; rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            qspi_rd_valid = 1'b1; qspi_rd_data = 8'(i + 1);
            @(negedge clk);
        end
        qspi_rd_valid = 1'b0;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rst_mid fifo_filled: got %b want 1", rd_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({rd_valid, fsm_ready, qspi_rd_ready, qspi_start, txn_done} !== 5'b01000) begin
            errors++; $display("FAIL rst_mid flushed: got %b want 01000", {rd_valid, fsm_ready, qspi_rd_ready, qspi_start, txn_done}); end
        test_read(4, 24'h000200, 0, "read_after_rst");
    endtask

    initial begin
        test_reset();
        test_read(16, 24'h001234, 0, "read16");
        test_write(16, {128'hFFEEDDCCBBAA99887766554433221100, 128'h00112233445566778899AABBCCDDEEFF}, 0, "write16");
        test_read(32, 24'h0A0000, 10, "read32_stall");
        test_bad_len(0, "len0");
        test_bad_len(33, "len33");
        test_write(16, {128'd0, 128'h00112233445566778899AABBCCDDEEFF}, 8, "write_early_done");
        test_reset_mid_read();
        test_read(1, 24'h7FFFFF, 0, "read1");
        for (int i = 0; i < 8; i++) pay_r[32*i +: 32] = $urandom();
        test_write(32, pay_r, 0, "write32");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_txn_fsm.md
Name: mem_txn_fsm

Overview:
- Transaction FSM between the host command port and the QSPI flash controller.
- Accepts one decoded command at a time: read/write flag, 24-bit address, byte length, and for writes a 256-bit buffered payload.
- Issues the command to the QSPI controller and moves the bytes.
- Reads: streams bytes to the command port over an 8-bit valid/ready link through a small FIFO. Writes: serialises the payload to QSPI.
- Signals completion with a one-cycle txn_done pulse.

Parameters:
- FIFO_DEPTH, 4: read-data FIFO entries (power of two, >=2).
- MAX_LEN, 32: largest legal byte count (256 bits).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command strobe; sampled only in IDLE
- cmd_rw  in  1  1 = read from flash, 0 = write to flash
- cmd_addr  in  24  flash byte address
- cmd_len  in  9  byte count
- wr_data  in  256  write payload, right-aligned: byte k sent = wr_data[8*(len-k)-1 -: 8], k = 0..len-1 (MSB-first)
- wr_data_valid  in  1  payload ready
- fsm_ready  out  1  high only in IDLE
- rd_data  out  8  read byte to command port (FIFO head)
- rd_valid  out  1  FIFO non-empty
- rd_ready  in  1  command port accepts byte
- txn_done  out  1  one-cycle completion pulse
- txn_err  out  1  one-cycle, coincident with txn_done when the transaction failed
- qspi_start  out  1  command request
- qspi_rw, qspi_addr[23:0], qspi_len[8:0]  out  command fields, stable while qspi_start is high
- qspi_ready  in  1  QSPI accepts the command
- qspi_rd_data  in  8  byte from flash
- qspi_rd_valid  in  1  flash byte valid
- qspi_rd_ready  out  1  = !fifo_full
- qspi_wr_data  out  8  byte to flash
- qspi_wr_valid  out  1  write byte valid
- qspi_wr_ready  in  1  QSPI accepts the write byte
- qspi_done  in  1  QSPI transaction finished (pulse)

Behaviour:
- Reset: state IDLE, FIFO flushed, byte counters 0, every output 0 except fsm_ready = 1. Reset applies mid-transaction with no further QSPI strobes; the QSPI controller is reset in the same cycle.
- States: IDLE, LOAD, ISSUE, WRITE, READ, WAIT_DONE, DONE.
- IDLE:
  - On cmd_valid, latch rw/addr/len.
  - If len == 0 or len > MAX_LEN, go to DONE with the error flag set; QSPI sees no activity.
  - Else a write goes to LOAD; a read goes to ISSUE.
- LOAD: wait for wr_data_valid, then latch wr_data into a shift register and go to ISSUE. Arrival in the same cycle as entry is honoured on the next edge.
- ISSUE:
  - qspi_start is high and fields are stable until qspi_ready is sampled high.
  - Then drop qspi_start; a write goes to WRITE, a read goes to READ.
- WRITE:
  - qspi_wr_valid is high with the current byte.
  - On each qspi_wr_ready handshake, shift left 8 and increment the count.
  - After the len-th handshake go to WAIT_DONE.
- READ:
  - Push on qspi_rd_valid && qspi_rd_ready and count pushes.
  - Pop on rd_valid && rd_ready. Simultaneous push and pop leaves occupancy unchanged; push into a full FIFO is impossible because ready is low.
  - Pushes beyond len are dropped and set the error flag.
- Completion:
  - A read leaves READ when qspi_done has been seen (sticky), pushes == len, and the FIFO is empty after the final pop.
  - WAIT_DONE leaves on qspi_done.
- DONE: txn_done = 1 (and txn_err if the flag is set) for exactly one cycle, then IDLE. The flag clears on IDLE entry.
- Error paths:
  - qspi_done before all len bytes are transferred: set the error flag, discard the remaining write bytes, and go to DONE once the FIFO drains.
  - cmd_valid outside IDLE is ignored.
- Latency:
  - Read: cmd_valid at edge N gives qspi_start from N+1.
  - First flash byte pushed at edge M gives rd_valid high from M+1.
  - Final pop at edge P gives txn_done high in P+1.
- Counters are 6 bits. Addresses are passed through unchanged; there is no wrap handling.

Test Plan:
- Read len 16, addr 0x001234, rd_ready held high -> qspi_start 1 cycle after cmd, qspi_len = 16, rd_data bytes appear in flash order, one txn_done, txn_err = 0.
- Write len 16, wr_data[127:0] = 0x00112233...FF -> qspi_wr_data sequence 0x00,0x11,...,0xFF; txn_done the cycle after qspi_done.
- Read len 32, rd_ready low for 10 cycles -> qspi_rd_ready drops after 4 pushes, no byte lost; all 32 bytes delivered after rd_ready rises.
- cmd_len = 0 and cmd_len = 33 -> txn_done and txn_err pulse 2 cycles after cmd, qspi_start never asserted.
- qspi_done after 8 of 16 write bytes -> qspi_wr_valid drops, txn_done with txn_err = 1.
- rst asserted mid-READ with 3 bytes in the FIFO -> next cycle rd_valid = 0, fsm_ready = 1; next read proceeds normally.
